monitor_transiciones: RTL and testbench



---
 rtl/monitor_transiciones.sv | 149 ++++++++++++++
 tb/tb_monitor_transiciones.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/monitor_transiciones.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | monitor_transiciones: per-channel bus Hamming-distance accumulator with  |
// | one-cycle read port. Optional macro CONTADOR_SATURACION_EN saturates.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module monitor_transiciones #(
   parameter int DATA_W  = 8,
   parameter int NUM_CNT = 3,
   parameter int DIR_W   = 2,
   parameter int CNT_W   = 32
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic [DATA_W-1:0] muestra,
   input  logic [DIR_W-1:0]  canal,
   input  logic              habilitar,
   input  logic              borrar,
   input  logic              rd_req,
   input  logic [DIR_W-1:0]  rd_dir,
   output logic [CNT_W-1:0]  rd_dato,
   output logic              rd_valido,
   output logic              ocupado
`ifdef CONTADOR_SATURACION_EN
   ,
   output logic              saturado
`endif
);

   typedef enum logic [1:0] {
      INICIO   = 2'd0,
      ACTIVO   = 2'd1,
      BORRANDO = 2'd2
   } estado_t;

   estado_t           r_estado;
   logic [DATA_W-1:0] r_prev;
   logic [CNT_W-1:0]  r_cnt [NUM_CNT];
   logic [DIR_W-1:0]  r_idx_borrar;

   logic [DATA_W-1:0] w_xor;
   logic [CNT_W-1:0]  w_delta;
   logic [CNT_W-1:0]  w_cnt_sel;
   logic [CNT_W-1:0]  w_rd_val;
   logic [CNT_W-1:0]  w_nuevo;
   logic              w_canal_ok;

   always_comb begin
      w_xor      = muestra ^ r_prev;
      w_delta    = '0;
      for (int i = 0; i < DATA_W; i++) begin
         w_delta = w_delta + CNT_W'(w_xor[i]);
      end
      w_cnt_sel  = '0;
      w_rd_val   = '0;
      w_canal_ok = 1'b0;
      for (int k = 0; k < NUM_CNT; k++) begin
         if (canal == DIR_W'(k)) begin
            w_cnt_sel  = r_cnt[k];
            w_canal_ok = 1'b1;
         end
         if (rd_dir == DIR_W'(k)) begin
            w_rd_val = r_cnt[k];
         end
      end
   end

`ifdef CONTADOR_SATURACION_EN
   logic [CNT_W:0] w_suma;
   logic           w_tope;

   // One extra bit catches the carry so the sum can be clamped to all-ones.
   always_comb begin
      w_suma  = {1'b0, w_cnt_sel} + {1'b0, w_delta};
      w_tope  = (w_suma >= {1'b0, {CNT_W{1'b1}}});
      w_nuevo = w_suma[CNT_W] ? {CNT_W{1'b1}} : w_suma[CNT_W-1:0];
   end
`else
   assign w_nuevo = w_cnt_sel + w_delta;
`endif

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_estado     <= INICIO;
         r_prev       <= '0;
         r_idx_borrar <= '0;
         rd_dato      <= '0;
         rd_valido    <= 1'b0;
         ocupado      <= 1'b0;
         for (int k = 0; k < NUM_CNT; k++) begin
            r_cnt[k] <= '0;
         end
`ifdef CONTADOR_SATURACION_EN
         saturado     <= 1'b0;
`endif
      end else begin
         rd_valido <= 1'b0;
         case (r_estado)
            BORRANDO: begin
               for (int k = 0; k < NUM_CNT; k++) begin
                  if (r_idx_borrar == DIR_W'(k)) begin
                     r_cnt[k] <= '0;
                  end
               end
               if (r_idx_borrar == DIR_W'(NUM_CNT - 1)) begin
                  r_estado     <= INICIO;
                  ocupado      <= 1'b0;
                  r_idx_borrar <= '0;
`ifdef CONTADOR_SATURACION_EN
                  saturado     <= 1'b0;
`endif
               end else begin
                  r_idx_borrar <= r_idx_borrar + DIR_W'(1);
               end
            end
            default: begin
               // Read sees the counters before this cycle's accumulation.
               if (rd_req) begin
                  rd_dato   <= w_rd_val;
                  rd_valido <= 1'b1;
               end
               if (borrar) begin
                  r_estado     <= BORRANDO;
                  ocupado      <= 1'b1;
                  r_idx_borrar <= '0;
               end else if (habilitar) begin
                  r_prev   <= muestra;
                  r_estado <= ACTIVO;
                  // The first sample after INICIO only seeds the reference.
                  if ((r_estado == ACTIVO) && w_canal_ok) begin
                     for (int k = 0; k < NUM_CNT; k++) begin
                        if (canal == DIR_W'(k)) begin
                           r_cnt[k] <= w_nuevo;
                        end
                     end
`ifdef CONTADOR_SATURACION_EN
                     if (w_tope) begin
                        saturado <= 1'b1;
                     end
`endif
                  end
               end
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_monitor_transiciones.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_monitor_transiciones: randomized bench with a behavioural model.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_monitor_transiciones;

   logic        clk = 1'b0;
   logic        reset_L = 1'b0;
   logic [7:0]  muestra = '0;
   logic [1:0]  canal = '0;
   logic        habilitar = 1'b0;
   logic        borrar = 1'b0;
   logic        rd_req = 1'b0;
   logic [1:0]  rd_dir = '0;
   logic [31:0] rd_dato;
   logic        rd_valido;
   logic        ocupado;

   logic [7:0]  mue4 = '0;
   logic [1:0]  canal4 = '0;
   logic        hab4 = 1'b0;
   logic        borrar4 = 1'b0;
   logic        rdreq4 = 1'b0;
   logic [1:0]  rddir4 = '0;
   logic [3:0]  dato4;
   logic        val4;
   logic        ocup4;
`ifdef CONTADOR_SATURACION_EN
   logic        saturado;
   logic        sat4;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural reference state
   logic [31:0] m_cnt [4];
   logic [7:0]  m_prev;
   bit          m_ref;
   int          m_clr;
   logic [31:0] m_dato;
   bit          m_valid;
   bit          m_ocup;

   monitor_transiciones u_dut (
      .clk(clk), .reset_L(reset_L), .muestra(muestra), .canal(canal),
      .habilitar(habilitar), .borrar(borrar), .rd_req(rd_req), .rd_dir(rd_dir),
      .rd_dato(rd_dato), .rd_valido(rd_valido), .ocupado(ocupado)
`ifdef CONTADOR_SATURACION_EN
      , .saturado(saturado)
`endif
   );

   monitor_transiciones #(.CNT_W(4)) u_dut4 (
      .clk(clk), .reset_L(reset_L), .muestra(mue4), .canal(canal4),
      .habilitar(hab4), .borrar(borrar4), .rd_req(rdreq4), .rd_dir(rddir4),
      .rd_dato(dato4), .rd_valido(val4), .ocupado(ocup4)
`ifdef CONTADOR_SATURACION_EN
      , .saturado(sat4)
`endif
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int k = 0; k < 4; k++) m_cnt[k] = '0;
      m_prev  = '0;
      m_ref   = 0;
      m_clr   = 0;
      m_dato  = '0;
      m_valid = 0;
      m_ocup  = 0;
   endtask

   // Advance one clock, applying the spec rules to the model from the current inputs.
   task automatic ciclo();
      m_valid = 0;
      if (m_clr > 0) begin
         m_clr = m_clr - 1;
      end else begin
         if (rd_req) begin
            m_valid = 1;
            m_dato  = (rd_dir < 3) ? m_cnt[rd_dir] : 32'd0;
         end
         if (borrar) begin
            m_clr = 3;
            for (int k = 0; k < 4; k++) m_cnt[k] = '0;
            m_ref = 0;
         end else if (habilitar) begin
            if (m_ref && canal < 3) m_cnt[canal] = m_cnt[canal] + 32'($countones(muestra ^ m_prev));
            m_prev = muestra;
            m_ref  = 1;
         end
      end
      m_ocup = (m_clr > 0);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      habilitar = 0; borrar = 0; rd_req = 0; canal = 0; rd_dir = 0; muestra = 0;
      hab4 = 0; borrar4 = 0; rdreq4 = 0; canal4 = 0; rddir4 = 0; mue4 = 0;
   endtask

   task automatic apply_reset();
      idle();
      reset_L = 0;
      @(posedge clk);
      #1;
      reset_L = 1;
      model_reset();
   endtask

   task automatic test_reset();
      habilitar = 1; muestra = 8'hA5; rd_req = 1;
      #2 reset_L = 0;
      #1;
      n_tests++;
      if (rd_dato !== 32'd0 || rd_valido !== 1'b0 || ocupado !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: got dato=%0d valido=%0b ocupado=%0b expected 0/0/0", rd_dato, rd_valido, ocupado);
      end
      apply_reset();
   endtask

   task automatic test_basico();
      logic [7:0] seq [3];
      apply_reset();
      seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h00;
      for (int i = 0; i < 3; i++) begin
         habilitar = 1; canal = 0; muestra = seq[i];
         ciclo();
      end
      habilitar = 0; rd_req = 1; rd_dir = 0;
      ciclo();
      n_tests++;
      if (rd_valido !== 1'b1 || rd_dato !== 32'd16) begin
         n_fail++;
         $display("FAIL basico_lectura: got valido=%0b dato=%0d expected 1/16", rd_valido, rd_dato);
      end
      rd_req = 0;
      ciclo();
      n_tests++;
      if (rd_valido !== 1'b0 || rd_dato !== 32'd16) begin
         n_fail++;
         $display("FAIL basico_pulso: got valido=%0b dato=%0d expected 0/16", rd_valido, rd_dato);
      end
   endtask

   task automatic test_mismo_ciclo();
      apply_reset();
      habilitar = 1; canal = 1; muestra = 8'h0F;
      ciclo();
      muestra = 8'hF0; rd_req = 1; rd_dir = 1;
      ciclo();
      n_tests++;
      if (rd_valido !== 1'b1 || rd_dato !== 32'd0) begin
         n_fail++;
         $display("FAIL mismo_ciclo_pre: got valido=%0b dato=%0d expected 1/0", rd_valido, rd_dato);
      end
      habilitar = 0;
      ciclo();
      n_tests++;
      if (rd_valido !== 1'b1 || rd_dato !== 32'd8) begin
         n_fail++;
         $display("FAIL mismo_ciclo_post: got valido=%0b dato=%0d expected 1/8", rd_valido, rd_dato);
      end
      rd_req = 0;
   endtask

   task automatic test_borrar();
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         habilitar = 1; canal = 2'($urandom_range(0, 2)); muestra = 8'($urandom);
         ciclo();
      end
      habilitar = 0; borrar = 1;
      ciclo();
      n_tests++;
      if (ocupado !== 1'b1) begin
         n_fail++;
         $display("FAIL borrar_inicio: got ocupado=%0b expected 1", ocupado);
      end
      borrar = 0; rd_req = 1; rd_dir = 1; habilitar = 1; muestra = 8'h5A;
      for (int i = 0; i < 3; i++) begin
         ciclo();
         n_tests++;
         if (rd_valido !== 1'b0 || ocupado !== (i < 2)) begin
            n_fail++;
            $display("FAIL borrar_ciclo%0d: got valido=%0b ocupado=%0b expected 0/%0b", i, rd_valido, ocupado, (i < 2));
         end
      end
      habilitar = 0;
      for (int k = 0; k < 3; k++) begin
         rd_dir = 2'(k);
         ciclo();
         n_tests++;
         if (rd_valido !== 1'b1 || rd_dato !== 32'd0) begin
            n_fail++;
            $display("FAIL borrar_cero%0d: got valido=%0b dato=%0d expected 1/0", k, rd_valido, rd_dato);
         end
      end
      rd_req = 0; habilitar = 1; canal = 0; muestra = 8'hFF;
      ciclo();
      habilitar = 0; rd_req = 1; rd_dir = 0;
      ciclo();
      n_tests++;
      if (rd_valido !== 1'b1 || rd_dato !== 32'd0) begin
         n_fail++;
         $display("FAIL borrar_referencia: got valido=%0b dato=%0d expected 1/0", rd_valido, rd_dato);
      end
      rd_req = 0;
   endtask

   task automatic test_fuera_rango();
      apply_reset();
      for (int i = 0; i < 10; i++) begin
         habilitar = 1; canal = 2'($urandom_range(0, 2)); muestra = 8'($urandom);
         ciclo();
      end
      for (int i = 0; i < 6; i++) begin
         canal = 3; muestra = (i % 2 == 0) ? 8'h00 : 8'hFF;
         ciclo();
      end
      habilitar = 0; rd_req = 1;
      for (int k = 0; k < 4; k++) begin
         rd_dir = 2'(k);
         ciclo();
         n_tests++;
         if (rd_valido !== 1'b1 || rd_dato !== m_dato) begin
            n_fail++;
            $display("FAIL fuera_rango_lee%0d: got valido=%0b dato=%0d expected 1/%0d", k, rd_valido, rd_dato, m_dato);
         end
      end
      n_tests++;
      if (rd_dato !== 32'd0) begin
         n_fail++;
         $display("FAIL fuera_rango_dir3: got dato=%0d expected 0", rd_dato);
      end
      rd_req = 0;
   endtask

   task automatic test_aleatorio();
      apply_reset();
      for (int i = 0; i < 400; i++) begin
         habilitar = ($urandom_range(0, 9) < 8);
         canal     = 2'($urandom_range(0, 3));
         muestra   = 8'($urandom);
         rd_req    = $urandom_range(0, 1) == 1;
         rd_dir    = 2'($urandom_range(0, 3));
         borrar    = ($urandom_range(0, 99) < 3);
         ciclo();
         n_tests++;
         if (rd_valido !== m_valid || rd_dato !== m_dato || ocupado !== m_ocup) begin
            n_fail++;
            $display("FAIL aleatorio_%0d: got valido=%0b dato=%0d ocupado=%0b expected %0b/%0d/%0b",
                     i, rd_valido, rd_dato, ocupado, m_valid, m_dato, m_ocup);
         end
      end
      idle();
   endtask

   task automatic test_back_to_back();
      apply_reset();
      for (int i = 0; i < 40; i++) begin
         habilitar = $urandom_range(0, 1) == 1;
         canal     = 2'($urandom_range(0, 2));
         muestra   = 8'($urandom);
         rd_req    = 1;
         rd_dir    = 2'(i % 4);
         ciclo();
         n_tests++;
         if (rd_valido !== 1'b1 || rd_dato !== m_dato) begin
            n_fail++;
            $display("FAIL back_to_back_%0d: got valido=%0b dato=%0d expected 1/%0d", i, rd_valido, rd_dato, m_dato);
         end
      end
      idle();
   endtask

   task automatic test_reset_async();
      apply_reset();
      habilitar = 1; canal = 0; muestra = 8'h00;
      ciclo();
      muestra = 8'h0F;
      ciclo();
      habilitar = 0; borrar = 1;
      ciclo();
      borrar = 0;
      #2 reset_L = 0;
      #1;
      n_tests++;
      if (ocupado !== 1'b0 || rd_valido !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_en_borrado: got ocupado=%0b valido=%0b expected 0/0", ocupado, rd_valido);
      end
      reset_L = 1;
      model_reset();
      ciclo();
      habilitar = 1; muestra = 8'h00;
      ciclo();
      muestra = 8'h07;
      ciclo();
      habilitar = 0; rd_req = 1; rd_dir = 0;
      ciclo();
      rd_req = 0;
      n_tests++;
      if (rd_valido !== 1'b1 || rd_dato !== 32'd3) begin
         n_fail++;
         $display("FAIL reset_lectura_previa: got valido=%0b dato=%0d expected 1/3", rd_valido, rd_dato);
      end
      #2 reset_L = 0;
      #1;
      n_tests++;
      if (rd_valido !== 1'b0 || rd_dato !== 32'd0 || ocupado !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_en_lectura: got valido=%0b dato=%0d ocupado=%0b expected 0/0/0", rd_valido, rd_dato, ocupado);
      end
      reset_L = 1;
      model_reset();
      ciclo();
      habilitar = 1; muestra = 8'hFF;
      ciclo();
      muestra = 8'h00;
      ciclo();
      habilitar = 0; rd_req = 1; rd_dir = 0;
      ciclo();
      n_tests++;
      if (rd_valido !== 1'b1 || rd_dato !== 32'd8) begin
         n_fail++;
         $display("FAIL reset_inicio: got valido=%0b dato=%0d expected 1/8", rd_valido, rd_dato);
      end
      rd_req = 0;
   endtask

   task automatic test_cnt4();
      logic [3:0] esperado;
      apply_reset();
`ifdef CONTADOR_SATURACION_EN
      esperado = 4'd15;
`else
      esperado = 4'd8;
`endif
      for (int i = 0; i < 4; i++) begin
         hab4 = 1; canal4 = 0; mue4 = (i % 2 == 0) ? 8'h00 : 8'hFF;
         ciclo();
      end
      hab4 = 0; rdreq4 = 1; rddir4 = 0;
      ciclo();
      rdreq4 = 0;
      n_tests++;
      if (val4 !== 1'b1 || dato4 !== esperado) begin
         n_fail++;
         $display("FAIL cnt4_desborde: got valido=%0b dato=%0d expected 1/%0d", val4, dato4, esperado);
      end
`ifdef CONTADOR_SATURACION_EN
      n_tests++;
      if (sat4 !== 1'b1) begin
         n_fail++;
         $display("FAIL cnt4_saturado: got %0b expected 1", sat4);
      end
`endif
      borrar4 = 1;
      ciclo();
      borrar4 = 0;
      for (int i = 0; i < 3; i++) ciclo();
      n_tests++;
      if (ocup4 !== 1'b0) begin
         n_fail++;
         $display("FAIL cnt4_fin_borrado: got ocupado=%0b expected 0", ocup4);
      end
`ifdef CONTADOR_SATURACION_EN
      n_tests++;
      if (sat4 !== 1'b0) begin
         n_fail++;
         $display("FAIL cnt4_saturado_borrado: got %0b expected 0", sat4);
      end
`endif
   endtask

   initial begin
      model_reset();
      apply_reset();
      test_reset();
      test_basico();
      test_mismo_ciclo();
      test_borrar();
      test_fuera_rango();
      test_back_to_back();
      test_reset_async();
      test_cnt4();
      test_aleatorio();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
